// File: rtl/acorn_phase_ctrl.sv
// Phase sequencer for the bit-serial ACORN-128 datapath: one state update per cycle through
// INIT/AD/ENC/FIN, driving m/ca/cb and collecting ciphertext and tag bits from ks_bit.
module acorn_phase_ctrl #(
    parameter int AD_BITS  = 128,
    parameter int MSG_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [127:0]        key,
    input  logic [127:0]        iv,
    input  logic [AD_BITS-1:0]  ad,
    input  logic [MSG_BITS-1:0] pt,
    input  logic                ks_bit,
    output logic                clr_state,
    output logic                step_en,
    output logic                m_bit,
    output logic                ca_bit,
    output logic                cb_bit,
    output logic [2:0]          phase,
    output logic                busy,
    output logic                done,
    output logic [MSG_BITS-1:0] ct,
    output logic [127:0]        tag
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_INIT = 3'd2,
        S_AD   = 3'd3,
        S_ENC  = 3'd4,
        S_FIN  = 3'd5,
        S_DONE = 3'd6
    } phase_e;

    localparam logic [11:0] INIT_LAST  = 12'd1791;
    localparam logic [11:0] FIN_LAST   = 12'd767;
    localparam logic [11:0] TAG_FIRST  = 12'd640;
    localparam logic [11:0] AD_END     = 12'(AD_BITS);
    localparam logic [11:0] AD_CA_END  = 12'(AD_BITS + 128);
    localparam logic [11:0] AD_LAST    = 12'(AD_BITS + 255);
    localparam logic [11:0] MSG_END    = 12'(MSG_BITS);
    localparam logic [11:0] MSG_CA_END = 12'(MSG_BITS + 128);
    localparam logic [11:0] MSG_LAST   = 12'(MSG_BITS + 255);

    phase_e                phase_q, phase_d;
    logic [11:0]           n_q, n_d;
    logic [MSG_BITS-1:0]   ct_q, ct_d;
    logic [127:0]          tag_q, tag_d;
    logic                  last_step;

    // Key/IV are indexed mod 128; INIT's wrap-around and IV window both fall out of n[6:0].
    logic key_bit, iv_bit, ad_bit, pt_bit;
    assign key_bit = key[n_q[6:0]];
    assign iv_bit  = iv[n_q[6:0]];
    assign ad_bit  = |(ad & (AD_BITS'(1) << n_q));
    assign pt_bit  = |(pt & (MSG_BITS'(1) << n_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= S_IDLE;
            n_q     <= '0;
            ct_q    <= '0;
            tag_q   <= '0;
        end else begin
            phase_q <= phase_d;
            n_q     <= n_d;
            ct_q    <= ct_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        phase_d   = phase_q;
        ct_d      = ct_q;
        tag_d     = tag_q;
        last_step = 1'b0;
        case (phase_q)
            S_IDLE: begin
                if (start) begin
                    phase_d = S_CLR;
                    ct_d    = '0;
                    tag_d   = '0;
                end
            end
            S_CLR:  phase_d = S_INIT;
            S_INIT: begin
                last_step = (n_q == INIT_LAST);
                if (last_step) phase_d = S_AD;
            end
            S_AD: begin
                last_step = (n_q == AD_LAST);
                if (last_step) phase_d = S_ENC;
            end
            S_ENC: begin
                last_step = (n_q == MSG_LAST);
                if (last_step) phase_d = S_ENC == S_ENC ? S_FIN : S_FIN;
                if (n_q < MSG_END) ct_d = ct_q | (MSG_BITS'(pt_bit ^ ks_bit) << n_q);
            end
            S_FIN: begin
                last_step = (n_q == FIN_LAST);
                if (last_step) phase_d = S_DONE;
                // Bits 640..767 of FIN map onto tag[0..127]; 640 is a multiple of 128.
                if (n_q >= TAG_FIRST) tag_d = tag_q | (128'(ks_bit) << n_q[6:0]);
            end
            S_DONE:  phase_d = S_IDLE;
            default: phase_d = S_IDLE;
        endcase
        n_d = (step_en && !last_step) ? n_q + 12'd1 : 12'd0;
    end

    always_comb begin
        clr_state = (phase_q == S_CLR);
        busy      = (phase_q == S_CLR) || (phase_q == S_INIT) || (phase_q == S_AD)
                 || (phase_q == S_ENC) || (phase_q == S_FIN);
        done      = (phase_q == S_DONE);
        phase     = phase_q;
        ct        = ct_q;
        tag       = tag_q;
        step_en   = 1'b0;
        m_bit     = 1'b0;
        ca_bit    = 1'b0;
        cb_bit    = 1'b0;
        case (phase_q)
            S_INIT: begin
                step_en = 1'b1;
                ca_bit  = 1'b1;
                cb_bit  = 1'b1;
                if (n_q < 12'd128)       m_bit = key_bit;
                else if (n_q < 12'd256)  m_bit = iv_bit;
                else if (n_q == 12'd256) m_bit = ~key_bit;
                else                     m_bit = key_bit;
            end
            S_AD: begin
                step_en = 1'b1;
                cb_bit  = 1'b1;
                ca_bit  = (n_q < AD_CA_END);
                m_bit   = (n_q < AD_END) ? ad_bit : (n_q == AD_END);
            end
            S_ENC: begin
                step_en = 1'b1;
                ca_bit  = (n_q < MSG_CA_END);
                m_bit   = (n_q < MSG_END) ? pt_bit : (n_q == MSG_END);
            end
            S_FIN: begin
                step_en = 1'b1;
                ca_bit  = 1'b1;
                cb_bit  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
